// File: rtl/pcint_ctrl.sv
// pcint_ctrl: pin-change interrupt controller for one port group (sync, masked edge detect, PCIF/PCIE, irq)
module pcint_ctrl #(
  parameter int p_width = 7,
  parameter int GROUP = 1,
  parameter logic [5:0] PCIFR_Address = 6'h1B,
  parameter logic [7:0] PCICR_Address = 8'h68,
  parameter logic [7:0] PCMSK_Address = 8'h6C
) (
  input  logic               cp2,
  input  logic               ireset,
  input  logic [5:0]         IO_Addr,
  input  logic               iore,
  input  logic               iowe,
  input  logic [7:0]         ram_Addr,
  input  logic               ramre,
  input  logic               ramwe,
  input  logic [7:0]         dbus_in,
  output logic [7:0]         dbus_out,
  output logic               out_en,
  input  logic [p_width-1:0] pin_i,
  output logic [p_width-1:0] pcmsk_o,
  output logic               pcie_o,
  output logic               irq,
  input  logic               irq_ack
);
  localparam logic [7:0] grp = 8'b1 << GROUP;
  logic [p_width-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, pcmsk_q, pcmsk_d;
  logic [1:0] cnt_q, cnt_d;
  logic pcie_q, pcie_d, pcif_q, pcif_d;
  logic warm, hit, pcifr_wr, pcicr_wr, pcmsk_wr, pcifr_rd, pcicr_rd, pcmsk_rd;
  assign warm = cnt_q == 2'd3;
  assign hit = |((s2_q ^ s3_q) & pcmsk_q) & warm;
  assign pcifr_wr = iowe & (IO_Addr == PCIFR_Address);
  assign pcicr_wr = ramwe & (ram_Addr == PCICR_Address);
  assign pcmsk_wr = ramwe & (ram_Addr == PCMSK_Address);
  assign pcifr_rd = iore & (IO_Addr == PCIFR_Address);
  assign pcicr_rd = ramre & (ram_Addr == PCICR_Address);
  assign pcmsk_rd = ramre & (ram_Addr == PCMSK_Address);
  assign out_en = pcifr_rd | pcicr_rd | pcmsk_rd;
  assign dbus_out = ({8{pcifr_rd & pcif_q}} & grp) | ({8{pcicr_rd & pcie_q}} & grp) | ({8{pcmsk_rd}} & 8'(pcmsk_q));
  assign pcmsk_o = pcmsk_q;
  assign pcie_o = pcie_q;
  assign irq = pcif_q & pcie_q;
  always_comb begin
    s1_d = pin_i;
    s2_d = s1_q;
    s3_d = s2_q;
    cnt_d = warm ? cnt_q : cnt_q + 2'd1;
    pcmsk_d = pcmsk_wr ? dbus_in[p_width-1:0] : pcmsk_q;
    pcie_d = pcicr_wr ? dbus_in[GROUP] : pcie_q;
    pcif_d = hit ? 1'b1 : (irq_ack | (pcifr_wr & dbus_in[GROUP])) ? 1'b0 : pcif_q;
  end
  always_ff @(posedge cp2) begin
    if (ireset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      cnt_q <= '0;
      pcmsk_q <= '0;
      pcie_q <= 1'b0;
      pcif_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      cnt_q <= cnt_d;
      pcmsk_q <= pcmsk_d;
      pcie_q <= pcie_d;
      pcif_q <= pcif_d;
    end
  end
endmodule

// File: tb/tb_pcint_ctrl.sv
// tb_pcint_ctrl: randomized self-checking bench for pcint_ctrl against a sample-history reference model
module tb_pcint_ctrl;
  localparam int W = 7;
  logic cp2 = 1'b0;
  logic ireset, iore, iowe, ramre, ramwe, irq_ack;
  logic [5:0] IO_Addr;
  logic [7:0] ram_Addr, dbus_in, dbus_out;
  logic [W-1:0] pin_i, pcmsk_o;
  logic out_en, pcie_o, irq;
  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] m_mask;
  logic m_pcie, m_pcif;
  logic [W-1:0] hist[$];
  always #5 cp2 = ~cp2;
  pcint_ctrl dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ram_Addr(ram_Addr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .out_en(out_en), .pin_i(pin_i), .pcmsk_o(pcmsk_o),
    .pcie_o(pcie_o), .irq(irq), .irq_ack(irq_ack)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  task automatic idle();
    ireset = 0; iore = 0; iowe = 0; ramre = 0; ramwe = 0; irq_ack = 0;
    IO_Addr = 6'h00; ram_Addr = 8'h00; dbus_in = 8'h00;
  endtask
  task automatic model_edge();
    logic hit, clr;
    int n;
    if (ireset) begin
      m_mask = '0; m_pcie = 0; m_pcif = 0;
      hist.delete();
    end else begin
      n = hist.size();
      hit = (n == 3) && (|((hist[1] ^ hist[0]) & m_mask));
      clr = irq_ack || (iowe && IO_Addr == 6'h1B && dbus_in[1]);
      if (hit) m_pcif = 1;
      else if (clr) m_pcif = 0;
      if (ramwe && ram_Addr == 8'h68) m_pcie = dbus_in[1];
      if (ramwe && ram_Addr == 8'h6C) m_mask = dbus_in[W-1:0];
      hist.push_back(pin_i);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask
  task automatic step();
    logic [7:0] r;
    logic en;
    #1;
    en = (iore && IO_Addr == 6'h1B) || (ramre && (ram_Addr == 8'h68 || ram_Addr == 8'h6C));
    r = 8'h00;
    if (iore && IO_Addr == 6'h1B && m_pcif) r = r | 8'h02;
    if (ramre && ram_Addr == 8'h68 && m_pcie) r = r | 8'h02;
    if (ramre && ram_Addr == 8'h6C) r = r | {1'b0, m_mask};
    check("out_en", out_en, en);
    check("dbus_out", dbus_out, r);
    @(posedge cp2);
    model_edge();
    @(negedge cp2);
    check("irq", irq, m_pcif & m_pcie);
    check("pcmsk_o", pcmsk_o, m_mask);
    check("pcie_o", pcie_o, m_pcie);
  endtask
  task automatic wr_ram(input logic [7:0] a, input logic [7:0] d);
    idle(); ramwe = 1; ram_Addr = a; dbus_in = d; step(); idle();
  endtask
  initial begin
    idle();
    pin_i = '1;
    m_mask = '0; m_pcie = 0; m_pcif = 0;
    @(negedge cp2);
    ireset = 1; step(); idle();
    check("rst_irq", irq, 0);
    check("rst_pcmsk", pcmsk_o, 0);
    wr_ram(8'h6C, 8'h7F);
    for (int i = 0; i < 20; i++) begin iore = 1; IO_Addr = 6'h1B; step(); end
    iore = 1; IO_Addr = 6'h1B; #1;
    check("warmup_quiet", dbus_out, 8'h00);
    idle();
    wr_ram(8'h6C, 8'h04);
    wr_ram(8'h68, 8'h02);
    step(); step(); step();
    pin_i[2] = ~pin_i[2];
    step(); step();
    check("pcif_not_yet", irq, 0);
    step();
    check("pcif_irq", irq, 1);
    iore = 1; IO_Addr = 6'h1B; #1;
    check("pcifr_read", dbus_out, 8'h02);
    idle(); iowe = 1; IO_Addr = 6'h1B; dbus_in = 8'h02; step(); idle();
    pin_i[3] = ~pin_i[3];
    for (int i = 0; i < 4; i++) step();
    check("unmasked_pin", irq, 0);
    wr_ram(8'h68, 8'h00);
    pin_i[2] = ~pin_i[2];
    for (int i = 0; i < 4; i++) step();
    check("pcie0_irq", irq, 0);
    wr_ram(8'h68, 8'h02);
    check("pcie_set_irq", irq, 1);
    pin_i[2] = ~pin_i[2];
    step(); step();
    irq_ack = 1; step(); idle();
    check("ack_vs_hit", irq, 1);
    irq_ack = 1; step(); idle();
    check("ack_clear", irq, 0);
    wr_ram(8'h68, 8'h00);
    wr_ram(8'h6C, 8'hA5);
    check("pcmsk_a5", pcmsk_o, 7'h25);
    ramre = 1; ram_Addr = 8'h6C; #1;
    check("pcmsk_read", dbus_out, 8'h25);
    ram_Addr = 8'h68; #1;
    check("pcicr_read", dbus_out, 8'h00);
    ram_Addr = 8'h6B; #1;
    check("off_addr_en", out_en, 0);
    idle();
    wr_ram(8'h68, 8'h02);
    pin_i[0] = ~pin_i[0];
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_irq", irq, 1);
    ireset = 1; step(); idle();
    check("post_reset_irq", irq, 0);
    check("post_reset_pcie", pcie_o, 0);
    for (int i = 0; i < 4; i++) step();
    pin_i[0] = ~pin_i[0];
    for (int i = 0; i < 4; i++) begin iore = 1; IO_Addr = 6'h1B; step(); end
    idle();
    for (int c = 0; c < 3000; c++) begin
      ireset = ($urandom_range(99) == 0);
      if ($urandom_range(3) == 0) pin_i = pin_i ^ W'($urandom);
      iore = 1'($urandom_range(1));
      IO_Addr = $urandom_range(1) ? 6'h1B : 6'($urandom);
      iowe = ($urandom_range(7) == 0);
      dbus_in = 8'($urandom);
      ramre = 1'($urandom_range(1));
      ramwe = ($urandom_range(5) == 0);
      case ($urandom_range(3))
        0: ram_Addr = 8'h68;
        1: ram_Addr = 8'h6C;
        2: ram_Addr = 8'h6B;
        default: ram_Addr = 8'($urandom);
      endcase
      irq_ack = ($urandom_range(7) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pcint_ctrl.md
Name: pcint_ctrl

Overview:
Pin-change interrupt controller for one port group. It has three jobs:
- Synchronises the port's pin inputs and detects per-pin edges qualified by the PCMSKx mask.
- Maintains the group's PCIF flag and PCIE enable bits, and raises an interrupt request to the interrupt controller.
- Exports the PCMSKx/PCIE values that the port's override logic consumes (the PCINT/PCIE1 inputs of the Port C wrapper).

One instance per group (group 1 = Port C, PCINT[14:8]). The top level ORs dbus_out of all instances and ports.

Parameters:
p_width, 7, number of pins in the group (1..8)
GROUP, 1, bit index this instance owns in PCIFR and PCICR (0..7)
PCIFR_Address, 6'h1B, I/O address of PCIFR
PCICR_Address, 8'h68, data-space address of PCICR
PCMSK_Address, 8'h6C, data-space address of this group's PCMSKx

Ports:
cp2  in  1  system clock, all state on rising edge
ireset  in  1  synchronous reset, active-high
IO_Addr  in  6  I/O address
iore  in  1  I/O read strobe
iowe  in  1  I/O write strobe
ram_Addr  in  8  data-space address (extended I/O)
ramre  in  1  data-space read strobe
ramwe  in  1  data-space write strobe
dbus_in  in  8  write data
dbus_out  out  8  read data; 8'h00 when out_en=0
out_en  out  1  this block drives dbus_out
pin_i  in  p_width  raw pin levels from the port
pcmsk_o  out  p_width  PCMSKx contents (to the port's PCINT input)
pcie_o  out  1  PCICR[GROUP] (to the port's PCIE input)
irq  out  1  interrupt request = PCIF & PCIE
irq_ack  in  1  one-cycle vector-taken pulse; clears PCIF

Behaviour:
Reset (cp2 edge with ireset=1):
- PCMSK=0, PCIE=0, PCIF=0.
- Sync stages s1/s2/s3=0, warm-up counter=0.
- Outputs: irq=0, pcmsk_o=0, pcie_o=0.

Sync/edge chain, every cycle:
- s1<=pin_i, s2<=s1, s3<=s2.
- hit = |((s2^s3) & PCMSK) & warm.

Warm-up counter:
- 2-bit counter increments from 0 after reset and saturates at 3.
- warm=(cnt==3). Suppresses false edges while the chain fills with real pin levels.

Latency:
- Pin toggle first sampled at edge k: hit is high in cycle k+1..k+2 and PCIF=1 after edge k+2.
- irq rises in the same cycle as PCIF when PCIE=1.
- Pulses shorter than one cp2 period may be missed (not guaranteed).

PCIF:
- Set when hit=1, regardless of PCIE.
- Cleared by irq_ack=1, or by an I/O write to PCIFR_Address with dbus_in[GROUP]=1. Writing 0 has no effect; other bits are ignored.
- Simultaneous set and clear in one cycle: set wins, PCIF stays 1.

Register writes:
- ramwe & ram_Addr==PCICR_Address: PCIE<=dbus_in[GROUP], other bits ignored.
- ramwe & ram_Addr==PCMSK_Address: PCMSK<=dbus_in[p_width-1:0].
- New mask/enable values apply from the next cycle.
- A mask bit set while that pin's s2!=s3 may flag that edge (accepted).

Reads (combinational, same cycle as strobe):
- out_en = (iore & IO_Addr==PCIFR_Address) | (ramre & (ram_Addr==PCICR_Address | ram_Addr==PCMSK_Address)).
- PCIFR read returns PCIF at bit GROUP, 0 elsewhere.
- PCICR read returns PCIE at bit GROUP, 0 elsewhere.
- PCMSK read returns PCMSK zero-extended to 8 bits.

Concurrency and reset:
- Multiple edges while PCIF=1: no further effect (single flag, no count).
- Reset mid-operation clears the flag and the warm-up counter. No irq until warm=1 and a new edge occurs.

Test Plan:
- Reset with pin_i=7'h7F, PCMSK=7'h7F written at cycle 1 -> PCIF stays 0 for 20 cycles; dbus_out=8'h00 on PCIFR read.
- PCMSK=7'h04, PCIE=1, toggle pin_i[2] at edge k -> PCIF=1 and irq=1 after edge k+2; PCIFR read = 8'h02; toggle pin_i[3] -> no flag.
- PCIE=0, toggle masked pin -> PCIF=1, irq=0; then write PCICR=8'h02 -> irq=1 next cycle; write PCIFR=8'h02 -> PCIF=0, irq=0.
- PCIF=1, pulse irq_ack in the same cycle as a new hit -> PCIF remains 1; irq_ack alone on the next cycle -> PCIF=0.
- Write PCMSK=8'hA5 via ramwe -> pcmsk_o=7'h25, PCMSK read = 8'h25; PCICR read = 8'h00 if PCIE=0; out_en=0 for ram_Addr=8'h6B.
- PCIF=1 with PCIE=1, assert ireset for 1 cycle -> PCIF=0, irq=0, pcmsk_o=0, pcie_o=0; the next pin toggle does not flag (mask cleared).
